// File: rtl/alt_scaler_cfg_master.sv
// alt_scaler_cfg_master: AXI4-Lite master that writes a register table into the scaler slave and verifies each entry by readback.
module alt_scaler_cfg_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_NUM_REGS = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = '0
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic                            ld_valid,
  input  logic [3:0]                      ld_idx,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   ld_data,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic                            error,
  output logic [1:0]                      err_code,
  output logic [3:0]                      err_idx,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);
  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA} state_t;
  localparam int IW = C_NUM_REGS > 1 ? $clog2(C_NUM_REGS) : 1;
  localparam logic [3:0] LAST = 4'(C_NUM_REGS - 1);
  state_t state_q, state_d;
  logic [3:0] idx_q, idx_d, err_idx_q, err_idx_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d, chk_q, chk_d;
  logic done_q, done_d, error_q, error_d;
  logic [1:0] err_code_q, err_code_d, rresp_q, rresp_d, fcode;
  logic [C_M_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d, cur;
  logic [C_M_AXI_DATA_WIDTH-1:0] tbl_q [C_NUM_REGS];
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr;
  logic ld_ok;
  assign cur = tbl_q[idx_q[IW-1:0]];
  assign addr = C_BASE_ADDR + C_M_AXI_ADDR_WIDTH'({idx_q, 2'b00});
  assign ld_ok = ld_valid && state_q == IDLE && {28'd0, ld_idx} < C_NUM_REGS;
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= IDLE;
      idx_q <= '0;
      aw_done_q <= 1'b0;
      w_done_q <= 1'b0;
      chk_q <= 1'b0;
      rdata_q <= '0;
      rresp_q <= '0;
      done_q <= 1'b0;
      error_q <= 1'b0;
      err_code_q <= '0;
      err_idx_q <= '0;
      for (int i = 0; i < C_NUM_REGS; i++) tbl_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      aw_done_q <= aw_done_d;
      w_done_q <= w_done_d;
      chk_q <= chk_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
      done_q <= done_d;
      error_q <= error_d;
      err_code_q <= err_code_d;
      err_idx_q <= err_idx_d;
      if (ld_ok) tbl_q[ld_idx[IW-1:0]] <= ld_data;
    end
  end
  // RDATA runs in two phases: capture the beat (chk_q=0), then judge the registered copy (chk_q=1)
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    aw_done_d = aw_done_q;
    w_done_d = w_done_q;
    chk_d = chk_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    done_d = 1'b0;
    error_d = error_q;
    err_code_d = err_code_q;
    err_idx_d = err_idx_q;
    fcode = 2'b00;
    case (state_q)
      IDLE: if (start) begin
        state_d = WADDR;
        idx_d = '0;
        aw_done_d = 1'b0;
        w_done_d = 1'b0;
        error_d = 1'b0;
        err_code_d = 2'b00;
        err_idx_d = '0;
      end
      WADDR: begin
        aw_done_d = aw_done_q | M_AXI_AWREADY;
        w_done_d = w_done_q | M_AXI_WREADY;
        if (aw_done_d && w_done_d) begin
          state_d = WRESP;
          aw_done_d = 1'b0;
          w_done_d = 1'b0;
        end
      end
      WRESP: if (M_AXI_BVALID) begin
        if (M_AXI_BRESP != 2'b00) fcode = 2'b01;
        else state_d = RADDR;
      end
      RADDR: if (M_AXI_ARREADY) state_d = RDATA;
      RDATA: if (!chk_q) begin
        if (M_AXI_RVALID) begin
          chk_d = 1'b1;
          rdata_d = M_AXI_RDATA;
          rresp_d = M_AXI_RRESP;
        end
      end else begin
        chk_d = 1'b0;
        if (rresp_q != 2'b00) fcode = 2'b10;
        else if (rdata_q != cur) fcode = 2'b11;
        else if (idx_q == LAST) begin
          state_d = IDLE;
          done_d = 1'b1;
        end else begin
          idx_d = idx_q + 4'd1;
          state_d = WADDR;
        end
      end
      default: state_d = IDLE;
    endcase
    if (fcode != 2'b00) begin
      state_d = IDLE;
      done_d = 1'b1;
      error_d = 1'b1;
      err_code_d = fcode;
      err_idx_d = idx_q;
    end
  end
  always_comb begin
    busy = state_q != IDLE;
    done = done_q;
    error = error_q;
    err_code = err_code_q;
    err_idx = err_idx_q;
    M_AXI_AWVALID = state_q == WADDR && !aw_done_q;
    M_AXI_WVALID = state_q == WADDR && !w_done_q;
    M_AXI_AWADDR = state_q == WADDR ? addr : '0;
    M_AXI_WDATA = state_q == WADDR ? cur : '0;
    M_AXI_AWPROT = 3'b000;
    M_AXI_WSTRB = '1;
    M_AXI_BREADY = state_q == WRESP;
    M_AXI_ARVALID = state_q == RADDR;
    M_AXI_ARADDR = state_q == RADDR ? addr : '0;
    M_AXI_ARPROT = 3'b000;
    M_AXI_RREADY = state_q == RDATA && !chk_q;
  end
endmodule
